// File: rtl/range_sensor_poller.sv
// range_sensor_poller
//
// Sequencer that sits in front of an i2c_master and keeps a range sensor
// polled. After enable it writes the sensor's configuration register once.
// It then repeats a fixed cycle: write the result-register pointer, read two
// bytes, present the distance on sample/sample_valid, and wait for the next
// period. A watchdog flags transactions that never complete.
//
// Optional feature: define RANGE_POLLER_AVG_EN to replace the raw reading with
// a two-point running average. The first reading after reset or re-enable
// always passes through unchanged.
//
// Ports
//   clk             system clock
//   reset_n         asynchronous active-low reset
//   enable          run polling while high
//   i2c_start       one-cycle transaction request to the master
//   i2c_mode        2'b11 two-byte write, 2'b01 one-byte write, 2'b00 two-byte read
//   i2c_slave_addr  constant SLAVE_ADDR
//   i2c_din0/1      first/second byte sent
//   i2c_dout        read data, first received byte in [15:8]
//   i2c_done        transaction complete (pulse or level)
//   sample          latest distance
//   sample_valid    one-cycle strobe when sample updates
//   busy            high whenever the sequencer is not idle
//   timeout_err     sticky watchdog flag
module range_sensor_poller #(
  parameter logic [6:0]  SLAVE_ADDR     = 7'h65,
  parameter logic [7:0]  CFG_REG        = 8'h00,
  parameter logic [7:0]  CFG_VAL        = 8'h01,
  parameter logic [7:0]  RESULT_REG     = 8'h1E,
  parameter int unsigned POLL_CYCLES    = 1_250_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        i2c_start,
  output logic [1:0]  i2c_mode,
  output logic [6:0]  i2c_slave_addr,
  output logic [7:0]  i2c_din0,
  output logic [7:0]  i2c_din1,
  input  logic [15:0] i2c_dout,
  input  logic        i2c_done,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE, CFG_START, CFG_WAIT, POLL_WAIT, PTR_START, PTR_WAIT, RD_START, RD_WAIT
  } state_t;

  localparam int PW = $clog2(POLL_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_CYCLES - 1);
  localparam logic [PW-1:0] POLL_ONE  = PW'(1);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] MODE_WR2 = 2'b11;
  localparam logic [1:0] MODE_WR1 = 2'b01;
  localparam logic [1:0] MODE_RD2 = 2'b00;

  state_t          state, state_n;
  logic            done_d, done_edge;
  logic [PW-1:0]   period_cnt, period_n;
  logic [WW-1:0]   wd_cnt, wd_n;
  logic            start_n;
  logic [1:0]      mode_n;
  logic [7:0]      din0_n, din1_n;
  logic [15:0]     sample_n, capture_val;
  logic            sv_n, err_n;

  assign i2c_slave_addr = SLAVE_ADDR;
  assign busy           = (state != IDLE);

  // Registered rising edge of done: a level-style done is seen exactly once,
  // and the extra stage gives the two-cycle done-to-sample_valid latency.
  // NOTE: every clocked register uses <= so all flops update from the same
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_d    <= 1'b0;
      done_edge <= 1'b0;
    end else begin
      done_d    <= i2c_done;
      done_edge <= i2c_done & ~done_d;
    end
  end

`ifdef RANGE_POLLER_AVG_EN
  logic        avg_primed;
  logic        capture;
  logic [16:0] avg_sum;

  assign capture     = (state == RD_WAIT) && done_edge && enable;
  assign avg_sum     = {1'b0, sample} + {1'b0, i2c_dout};
  assign capture_val = avg_primed ? avg_sum[16:1] : i2c_dout;

  // Cleared whenever a new run starts, so the first reading is not averaged
  // against a stale value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avg_primed <= 1'b0;
    end else if (state == IDLE && enable) begin
      avg_primed <= 1'b0;
    end else if (capture) begin
      avg_primed <= 1'b1;
    end
  end
`else
  assign capture_val = i2c_dout;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      period_cnt   <= '0;
      wd_cnt       <= '0;
      i2c_start    <= 1'b0;
      i2c_mode     <= 2'b00;
      i2c_din0     <= 8'h00;
      i2c_din1     <= 8'h00;
      sample       <= 16'h0000;
      sample_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_n;
      period_cnt   <= period_n;
      wd_cnt       <= wd_n;
      i2c_start    <= start_n;
      i2c_mode     <= mode_n;
      i2c_din0     <= din0_n;
      i2c_din1     <= din1_n;
      sample       <= sample_n;
      sample_valid <= sv_n;
      timeout_err  <= err_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_n  = state;
    start_n  = 1'b0;
    mode_n   = i2c_mode;
    din0_n   = i2c_din0;
    din1_n   = i2c_din1;
    period_n = (period_cnt != '0) ? period_cnt - 1'b1 : period_cnt;
    wd_n     = wd_cnt;
    sample_n = sample;
    sv_n     = 1'b0;
    err_n    = timeout_err;

    case (state)
      IDLE: begin
        period_n = '0;
        if (enable) begin
          state_n = CFG_START;
          err_n   = 1'b0;
        end
      end

      CFG_START: begin
        if (!enable) begin
          state_n = IDLE;
        end else begin
          start_n = 1'b1;
          mode_n  = MODE_WR2;
          din0_n  = CFG_REG;
          din1_n  = CFG_VAL;
          wd_n    = '0;
          state_n = CFG_WAIT;
        end
      end

      PTR_START: begin
        if (!enable) begin
          state_n = IDLE;
        end else begin
          start_n  = 1'b1;
          mode_n   = MODE_WR1;
          din0_n   = RESULT_REG;
          period_n = POLL_LOAD;
          wd_n     = '0;
          state_n  = PTR_WAIT;
        end
      end

      RD_START: begin
        if (!enable) begin
          state_n = IDLE;
        end else begin
          start_n = 1'b1;
          mode_n  = MODE_RD2;
          wd_n    = '0;
          state_n = RD_WAIT;
        end
      end

      // The next pointer write is launched one cycle before the counter
      // would reach zero, so consecutive starts are exactly POLL_CYCLES apart.
      POLL_WAIT: begin
        if (!enable) begin
          state_n = IDLE;
        end else if (period_cnt <= POLL_ONE) begin
          state_n = PTR_START;
        end
      end

      // Done takes priority over the watchdog, so a completion in the same
      // cycle as the timeout is still accepted. A transaction that finishes
      // after enable dropped is discarded.
      CFG_WAIT, PTR_WAIT, RD_WAIT: begin
        if (done_edge) begin
          if (!enable) begin
            state_n = IDLE;
          end else if (state == CFG_WAIT) begin
            state_n = PTR_START;
          end else if (state == PTR_WAIT) begin
            state_n = RD_START;
          end else begin
            sample_n = capture_val;
            sv_n     = 1'b1;
            state_n  = POLL_WAIT;
          end
        end else if (wd_cnt == WD_LAST) begin
          err_n   = 1'b1;
          state_n = enable ? POLL_WAIT : IDLE;
        end else begin
          wd_n = wd_cnt + 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_range_sensor_poller.sv
// Testbench for range_sensor_poller. Periods are scaled down (POLL 2000,
// TIMEOUT 600) so the run stays short; all timing relations are checked
// against these values. The bench plays the i2c_master: it logs every start
// and answers with done/dout after a chosen delay.
module tb_range_sensor_poller;

  localparam int P = 2000;
  localparam int T = 600;
`ifdef RANGE_POLLER_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        i2c_start;
  logic [1:0]  i2c_mode;
  logic [6:0]  i2c_slave_addr;
  logic [7:0]  i2c_din0;
  logic [7:0]  i2c_din1;
  logic [15:0] i2c_dout;
  logic        i2c_done;
  logic [15:0] sample;
  logic        sample_valid;
  logic        busy;
  logic        timeout_err;

  range_sensor_poller #(
    .POLL_CYCLES   (P),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .i2c_start     (i2c_start),
    .i2c_mode      (i2c_mode),
    .i2c_slave_addr(i2c_slave_addr),
    .i2c_din0      (i2c_din0),
    .i2c_din1      (i2c_din1),
    .i2c_dout      (i2c_dout),
    .i2c_done      (i2c_done),
    .sample        (sample),
    .sample_valid  (sample_valid),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #4 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_now();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Cycle counter and start log; the monitor runs exactly on the falling
  // edge, the main sequence one time unit later.
  int         cyc = 0;
  bit         prev_start = 1'b0;
  int         sv_count = 0;
  int         q_at[$];
  logic [1:0] q_mode[$];
  logic [7:0] q_d0[$];
  logic [7:0] q_d1[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (i2c_start) begin
      check("start_not_back_to_back", {31'b0, prev_start}, 32'd0);
      q_at.push_back(cyc);
      q_mode.push_back(i2c_mode);
      q_d0.push_back(i2c_din0);
      q_d1.push_back(i2c_din1);
    end
    if (sample_valid) sv_count++;
    prev_start = i2c_start;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_start(output int at, output logic [1:0] mode,
                            output logic [7:0] d0, output logic [7:0] d1);
    bit ok = 1'b0;
    at = 0; mode = 2'b00; d0 = 8'h00; d1 = 8'h00;
    for (int i = 0; i < 2 * P; i++) begin
      if (q_at.size() != 0) begin
        at   = q_at.pop_front();
        mode = q_mode.pop_front();
        d0   = q_d0.pop_front();
        d1   = q_d1.pop_front();
        ok   = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      check("start_within_budget", 32'd0, 32'd1);
      finish_now();
    end
  endtask

  // Answer the transaction started at cycle 'at': done rises 'delay' cycles
  // after the start and stays high for 'hold' cycles. sample_valid is
  // recorded for the three cycles after done rises.
  task automatic respond(input int at, input int delay, input int hold, input logic [15:0] data,
                         output logic [2:0] hist, output logic [15:0] smp,
                         output logic bsy, output logic err);
    hist = 3'b000; smp = 16'h0000; bsy = 1'b0; err = 1'b0;
    while (cyc < at + delay) tick();
    check("no_restart_in_flight", q_at.size(), 32'd0);
    i2c_done = 1'b1;
    i2c_dout = data;
    for (int k = 1; k <= 3 || k <= hold; k++) begin
      tick();
      if (k >= hold) i2c_done = 1'b0;
      if (k <= 3) hist[k-1] = sample_valid;
      if (k == 2) begin
        smp = sample;
        bsy = busy;
        err = timeout_err;
      end
    end
  endtask

  function automatic logic [15:0] model_sample(input logic [15:0] prev, input logic [15:0] raw,
                                               input bit first);
    logic [16:0] s;
    s = {1'b0, prev} + {1'b0, raw};
    return (!AVG || first) ? raw : s[16:1];
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_start"}, i2c_start, 32'd0);
    check({tag, "_mode"}, i2c_mode, 32'd0);
    check({tag, "_din0"}, i2c_din0, 32'd0);
    check({tag, "_din1"}, i2c_din1, 32'd0);
    check({tag, "_addr"}, i2c_slave_addr, 32'h65);
    check({tag, "_sample"}, sample, 32'd0);
    check({tag, "_sample_valid"}, sample_valid, 32'd0);
    check({tag, "_busy"}, busy, 32'd0);
    check({tag, "_timeout_err"}, timeout_err, 32'd0);
  endtask

  typedef struct {
    int          delay;
    int          hold;
    bit          hang;
    logic [15:0] data;
    logic [1:0]  mode;
    logic [7:0]  d0;
    logic [7:0]  d1;
    bit          chk_d0;
    bit          chk_d1;
    bit          chk_period;
    bit          err;
  } vec_t;

  vec_t        vecs[9];
  vec_t        v;
  int          at, en_at, last_ptr, err_at, exp_sv;
  logic [1:0]  m;
  logic [7:0]  d0, d1;
  logic [2:0]  hist;
  logic [15:0] smp, exp_s;
  logic        bsy, err;
  bit          first;

  initial begin
    //         delay hold hang data      mode   d0     d1     cd0 cd1 per err
    vecs[0] = '{300, 1, 0, 16'h0000, 2'b11, 8'h00, 8'h01, 1, 1, 0, 0};
    vecs[1] = '{40,  1, 0, 16'h0000, 2'b01, 8'h1E, 8'h00, 1, 0, 0, 0};
    vecs[2] = '{50,  1, 0, 16'hD97A, 2'b00, 8'h00, 8'h00, 0, 0, 0, 0};
    vecs[3] = '{40,  1, 0, 16'h0000, 2'b01, 8'h1E, 8'h00, 1, 0, 1, 0};
    vecs[4] = '{0,   1, 1, 16'h0000, 2'b00, 8'h00, 8'h00, 0, 0, 0, 1};
    vecs[5] = '{40,  1, 0, 16'h0000, 2'b01, 8'h1E, 8'h00, 1, 0, 1, 1};
    vecs[6] = '{60,  6, 0, 16'h0123, 2'b00, 8'h00, 8'h00, 0, 0, 0, 1};
    vecs[7] = '{40,  1, 0, 16'h0000, 2'b01, 8'h1E, 8'h00, 1, 0, 1, 1};
    vecs[8] = '{30,  1, 0, 16'h8001, 2'b00, 8'h00, 8'h00, 0, 0, 0, 1};

    reset_n  = 1'b0;
    enable   = 1'b0;
    i2c_done = 1'b0;
    i2c_dout = 16'h0000;
    exp_s    = 16'h0000;
    exp_sv   = 0;
    last_ptr = -1;
    tick();
    tick();
    check_idle("reset");
    reset_n = 1'b1;
    tick();
    enable = 1'b1;
    en_at  = cyc;
    first  = 1'b1;

    // Main polling sequence from the table.
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      wait_start(at, m, d0, d1);
      if (i == 0) check("enable_to_start", at - en_at, 32'd2);
      check($sformatf("v%0d_mode", i), m, v.mode);
      if (v.chk_d0) check($sformatf("v%0d_din0", i), d0, v.d0);
      if (v.chk_d1) check($sformatf("v%0d_din1", i), d1, v.d1);
      if (v.mode == 2'b01) begin
        if (v.chk_period) check($sformatf("v%0d_poll_period", i), at - last_ptr, P);
        last_ptr = at;
      end
      if (v.hang) begin
        err_at = -1;
        for (int j = 0; j < T + 50; j++) begin
          tick();
          if (timeout_err) begin
            err_at = cyc;
            break;
          end
        end
        check($sformatf("v%0d_timeout_latency", i), err_at - at, T);
      end else begin
        respond(at, v.delay, v.hold, v.data, hist, smp, bsy, err);
        if (v.mode == 2'b00) begin
          exp_s = model_sample(exp_s, v.data, first);
          first = 1'b0;
          exp_sv++;
          check($sformatf("v%0d_valid_strobe", i), hist, 3'b010);
          check($sformatf("v%0d_sample", i), smp, exp_s);
        end else begin
          check($sformatf("v%0d_no_strobe", i), hist, 3'b000);
        end
        check($sformatf("v%0d_timeout_err", i), err, v.err);
      end
    end

    // Asynchronous reset in the middle of a poll period.
    repeat (20) tick();
    reset_n = 1'b0;
    #1;
    check_idle("async_reset");
    enable = 1'b0;
    exp_s  = 16'h0000;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    enable = 1'b1;
    en_at  = cyc;
    first  = 1'b1;
    wait_start(at, m, d0, d1);
    check("rerun_cfg_latency", at - en_at, 32'd2);
    check("rerun_cfg_mode", m, 2'b11);
    respond(at, 20, 1, 16'h0000, hist, smp, bsy, err);
    wait_start(at, m, d0, d1);
    check("b_ptr_mode", m, 2'b01);
    respond(at, 20, 1, 16'h0000, hist, smp, bsy, err);

    // Done arrives in the same cycle the watchdog would fire: done wins.
    wait_start(at, m, d0, d1);
    check("b_rd_mode", m, 2'b00);
    respond(at, T - 2, 1, 16'h4242, hist, smp, bsy, err);
    exp_s = model_sample(exp_s, 16'h4242, first);
    first = 1'b0;
    exp_sv++;
    check("late_done_strobe", hist, 3'b010);
    check("late_done_sample", smp, exp_s);
    check("late_done_no_err", err, 1'b0);

    // Enable drops while the read is in flight: data discarded.
    wait_start(at, m, d0, d1);
    respond(at, 20, 1, 16'h0000, hist, smp, bsy, err);
    wait_start(at, m, d0, d1);
    check("c_rd_mode", m, 2'b00);
    enable = 1'b0;
    respond(at, 20, 1, 16'hFFFF, hist, smp, bsy, err);
    check("disable_no_strobe", hist, 3'b000);
    check("disable_sample_kept", smp, exp_s);
    check("disable_busy_low", bsy, 1'b0);

    // Configuration write times out one cycle before done would arrive;
    // the retry is the pointer write, not another configuration write.
    tick();
    enable = 1'b1;
    first  = 1'b1;
    wait_start(at, m, d0, d1);
    check("d_cfg_mode", m, 2'b11);
    respond(at, T - 1, 1, 16'h0000, hist, smp, bsy, err);
    check("cfg_timeout_no_strobe", hist, 3'b000);
    check("cfg_timeout_err", err, 1'b1);
    wait_start(at, m, d0, d1);
    check("retry_is_ptr_mode", m, 2'b01);
    check("retry_is_ptr_din0", d0, 8'h1E);
    respond(at, 20, 1, 16'h0000, hist, smp, bsy, err);
    wait_start(at, m, d0, d1);
    respond(at, 20, 1, 16'h0300, hist, smp, bsy, err);
    exp_s = model_sample(exp_s, 16'h0300, first);
    first = 1'b0;
    exp_sv++;
    check("d_rd1_strobe", hist, 3'b010);
    check("d_rd1_sample", smp, exp_s);
    wait_start(at, m, d0, d1);
    respond(at, 20, 1, 16'h0000, hist, smp, bsy, err);
    wait_start(at, m, d0, d1);
    respond(at, 20, 1, 16'h0100, hist, smp, bsy, err);
    exp_s = model_sample(exp_s, 16'h0100, first);
    exp_sv++;
    check("d_rd2_strobe", hist, 3'b010);
    check("d_rd2_sample", smp, exp_s);
    check("err_sticky_after_good_read", err, 1'b1);

    // Disable from POLL_WAIT, then re-enable clears the sticky error.
    enable = 1'b0;
    tick();
    tick();
    tick();
    check("idle_busy_low", busy, 1'b0);
    check("idle_err_kept", timeout_err, 1'b1);
    enable = 1'b1;
    tick();
    tick();
    check("reenable_err_cleared", timeout_err, 1'b0);
    check("reenable_busy", busy, 1'b1);

    check("sample_valid_count", sv_count, exp_sv);
    finish_now();
  end

endmodule
